// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_pkg                                                   |
// | Purpose : Shared width, state encoding and counter sizing for the    |
// |           sequential shift-add multiplier.                           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multu_seq_if                                               |
// | Purpose : Request/response bundle between the EX stage and the       |
// |           sequential multiplier.                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface multu_seq_if #(
  parameter int WIDTH = mult_pkg::WIDTH
);
  logic               Start;
  logic               Signed;
  logic [WIDTH-1:0]   SrcA;
  logic [WIDTH-1:0]   SrcB;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] MULTUAns;

  modport master (
    output Start, Signed, SrcA, SrcB,
    input  Busy, Done, MULTUAns
  );

  modport slave (
    input  Start, Signed, SrcA, SrcB,
    output Busy, Done, MULTUAns
  );
endinterface
`default_nettype wire

// File: rtl/mult_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_sign_fix                                              |
// | Purpose : Conditional two's-complement negate, y = (x ^ {N{neg}})+neg|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mult_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] x_i,
  input  logic         neg_i,
  output logic [N-1:0] y_o
);

  // Invert-and-increment when neg_i is set; pass-through otherwise
  always_comb begin
    y_o = (x_i ^ {N{neg_i}}) + N'(neg_i);
  end

endmodule
`default_nettype wire

// File: rtl/multu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multu_seq                                                  |
// | Purpose : WIDTH-cycle shift-add multiplier for MULT/MULTU feeding    |
// |           the Hi/Lo pair. Operands are reduced to magnitudes on       |
// |           acceptance and the sign is restored on the last iteration. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module multu_seq #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  multu_seq_if.slave  bus
);
  import mult_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // {partial product high half, remaining multiplier bits}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   ans_q, ans_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum_w;
  logic [2*WIDTH-1:0]   step_w;
  logic [2*WIDTH-1:0]   fixed_w;
  logic                 last_w;

  mult_sign_fix #(.N(WIDTH)) u_mag_a (
    .x_i   (bus.SrcA),
    .neg_i (bus.Signed & bus.SrcA[WIDTH-1]),
    .y_o   (mag_a)
  );

  mult_sign_fix #(.N(WIDTH)) u_mag_b (
    .x_i   (bus.SrcB),
    .neg_i (bus.Signed & bus.SrcB[WIDTH-1]),
    .y_o   (mag_b)
  );

  mult_sign_fix #(.N(2*WIDTH)) u_fix_res (
    .x_i   (step_w),
    .neg_i (neg_q),
    .y_o   (fixed_w)
  );

  // One shift-add step: conditional add into the upper half with carry, then shift right
  always_comb begin
    sum_w  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_w = {sum_w, acc_q[WIDTH-1:1]};
    last_w = (cnt_q == CW'(WIDTH-1));
  end

  // State, counter and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      ans_q   <= ans_d;
    end
  end

  // Next-state and datapath control; the product register only moves on the final step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    ans_d   = ans_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = BUSY;
          mcand_d = mag_a;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d   = bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = step_w;
        cnt_d = cnt_q + 1'b1;
        if (last_w) begin
          state_d = DONE;
          ans_d   = fixed_w;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Busy     = (state_q == BUSY);
  assign bus.Done     = (state_q == DONE);
  assign bus.MULTUAns = ans_q;

endmodule
`default_nettype wire

// File: tb/tb_multu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multu_seq                                               |
// | Purpose : Self-checking bench for multu_seq: directed table, random  |
// |           operands against an arithmetic model, restart/reset/back-  |
// |           to-back sequences.                                         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_multu_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [63:0] model_ans;

  multu_seq_if bus ();

  multu_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  // Exact product from plain arithmetic
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and watch edges E0..E33; optionally pulse Start again
  // so that it is sampled at E<restart_at>.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int restart_at, input string tag);
    logic busy_ok, done_ok, hold_ok, prod_ok;
    busy_ok = 1'b1; done_ok = 1'b1; hold_ok = 1'b1; prod_ok = 1'b1;
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Signed = sgn;
    bus.SrcA   = a;
    bus.SrcB   = b;
    for (int k = 0; k <= 33; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 31) begin
        if (bus.Busy !== 1'b1) busy_ok = 1'b0;
        if (bus.Done !== 1'b0) done_ok = 1'b0;
        if (bus.MULTUAns !== model_ans) hold_ok = 1'b0;
      end else if (k == 32) begin
        if (bus.Busy !== 1'b0) busy_ok = 1'b0;
        if (bus.Done !== 1'b1) done_ok = 1'b0;
        if (bus.MULTUAns !== exp) prod_ok = 1'b0;
      end else begin
        if (bus.Busy !== 1'b0) busy_ok = 1'b0;
        if (bus.Done !== 1'b0) done_ok = 1'b0;
        if (bus.MULTUAns !== exp) prod_ok = 1'b0;
      end
      bus.Start  = (restart_at >= 0) && (k == restart_at - 1);
      bus.Signed = 1'($urandom());
      bus.SrcA   = $urandom();
      bus.SrcB   = $urandom();
    end
    bus.Start = 1'b0;
    check({tag, " product"}, bus.MULTUAns, exp);
    check({tag, " busy_window"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " done_pulse"}, {63'd0, done_ok}, 64'd1);
    check({tag, " held_until_done"}, {63'd0, hold_ok & prod_ok}, 64'd1);
    model_ans = exp;
  endtask

  vec_t vecs[10];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_ans = 64'd0;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.SrcA = '0; bus.SrcB = '0;

    vecs[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[8] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[9] = '{1'b0, 32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset Busy", {63'd0, bus.Busy}, 64'd0);
    check("reset Done", {63'd0, bus.Done}, 64'd0);
    check("reset MULTUAns", bus.MULTUAns, 64'd0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, -1, $sformatf("vec%0d", i));

    // Random operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [31:0] ra, rb;
      s  = 1'($urandom());
      ra = $urandom();
      rb = $urandom();
      if (i == 0) ra = 32'h8000_0000;
      run_op(s, ra, rb, ref_mul(s, ra, rb), -1, $sformatf("rand%0d", i));
    end

    // Start again at E10 with other operands: ignored
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 10, "restart_e10");
    begin
      int extra_done;
      extra_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.Done || bus.Busy) extra_done++;
      end
      check("restart_e10 no_second_op", 64'(extra_done), 64'd0);
    end

    // Reset asserted at E15 of an operation
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.SrcA = 32'h0000_FFFF; bus.SrcB = 32'h0001_0001;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset Busy", {63'd0, bus.Busy}, 64'd0);
    check("midreset Done", {63'd0, bus.Done}, 64'd0);
    check("midreset MULTUAns", bus.MULTUAns, 64'd0);
    model_ans = 64'd0;
    @(negedge clk);
    reset = 1'b1;
    begin
      int stray;
      stray = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.Done || bus.Busy) stray++;
      end
      check("midreset no_done", 64'(stray), 64'd0);
    end
    run_op(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, -1, "after_reset");

    // Start held high: acceptances 34 edges apart, one Done each
    begin
      logic        bs[3];
      logic [31:0] ba[3], bb[3];
      int acc_edge[3];
      int nacc, ndone, op;
      logic prev_busy, prev_done, stable_ok, prod_ok, single_ok;
      for (int i = 0; i < 3; i++) begin
        bs[i] = 1'($urandom()); ba[i] = $urandom(); bb[i] = $urandom();
      end
      nacc = 0; ndone = 0; op = 0;
      prev_busy = 1'b0; prev_done = 1'b0;
      stable_ok = 1'b1; prod_ok = 1'b1; single_ok = 1'b1;
      @(negedge clk);
      bus.Start = 1'b1; bus.Signed = bs[0]; bus.SrcA = ba[0]; bus.SrcB = bb[0];
      for (int e = 0; e < 106; e++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.Busy && !prev_busy && nacc < 3) begin
          acc_edge[nacc] = e;
          nacc++;
        end
        if (bus.Busy && bus.Done) single_ok = 1'b0;
        if (bus.Done) begin
          if (prev_done) single_ok = 1'b0;
          if (op < 3) begin
            model_ans = ref_mul(bs[op], ba[op], bb[op]);
            if (bus.MULTUAns !== model_ans) prod_ok = 1'b0;
            op++;
          end
          ndone++;
          if (op < 3) begin
            bus.Signed = bs[op]; bus.SrcA = ba[op]; bus.SrcB = bb[op];
          end else begin
            bus.Start = 1'b0;
          end
        end else if (bus.MULTUAns !== model_ans) begin
          stable_ok = 1'b0;
        end
        prev_busy = bus.Busy;
        prev_done = bus.Done;
      end
      bus.Start = 1'b0;
      check("b2b accept_count", 64'(nacc), 64'd3);
      check("b2b done_count", 64'(ndone), 64'd3);
      if (nacc == 3) begin
        check("b2b gap01", 64'(acc_edge[1] - acc_edge[0]), 64'd34);
        check("b2b gap12", 64'(acc_edge[2] - acc_edge[1]), 64'd34);
      end else begin
        check("b2b gaps", 64'(nacc), 64'd3);
      end
      check("b2b products", {63'd0, prod_ok}, 64'd1);
      check("b2b stable", {63'd0, stable_ok}, 64'd1);
      check("b2b single_done", {63'd0, single_ok}, 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case of a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
